// File: rtl/debug_baud_ctrl.sv
// Sequencing controller for the debug auto-baud detector and UART baud generator.
// Arms the detector, validates its divisors, arbitrates with host writes and re-arms on line breaks.
module debug_baud_ctrl #(
    parameter logic [7:0] DEFAULT_DIV = 8'd26,
    parameter logic [7:0] MIN_DIV     = 8'd2,
    parameter int         REARM_CYC   = 4,
    parameter int         BREAK_BITS  = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ab_wr,
    input  logic [7:0] ab_div,
    input  logic [1:0] ab_rx_sel,
    output logic       ab_rst_n,
    output logic       ab_disabled,
    input  logic       host_wr,
    input  logic [7:0] host_div,
    input  logic       host_lock,
    input  logic       rx,
    output logic       baud_wr,
    output logic [7:0] baud_div,
    output logic [1:0] rx_sel,
    output logic       locked,
    output logic [1:0] state
);

    localparam int             RCW        = (REARM_CYC > 1) ? $clog2(REARM_CYC) : 1;
    localparam logic [RCW-1:0] REARM_LAST = RCW'(REARM_CYC - 1);
    localparam logic [3:0]     BIT_LAST   = 4'(BREAK_BITS - 1);

    typedef enum logic [1:0] {
        ST_REARM  = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2,
        ST_FORCED = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [RCW-1:0] rearm_cnt_q, rearm_cnt_d;
    logic [12:0]    sub_cnt_q, sub_cnt_d;
    logic [3:0]     bit_cnt_q, bit_cnt_d;
    logic           ab_rst_n_q, ab_rst_n_d;
    logic           ab_dis_q, ab_dis_d;
    logic [7:0]     baud_div_q, baud_div_d;
    logic           baud_wr_q, baud_wr_d;
    logic           wr_pend_q, wr_pend_d;
    logic [1:0]     rx_sel_q, rx_sel_d;
    logic           locked_q, locked_d;

    logic           host_ok;
    logic           ab_accept;
    logic           wr_evt;
    logic [12:0]    bit_last;

    assign host_ok  = host_wr && (host_div != 8'd0);
    // Detector divisor is pulse_width/32, so one bit-time is baud_div*32 clocks.
    assign bit_last = {baud_div_q, 5'b0} - 13'd1;

    always_comb begin
        state_d     = state_q;
        rearm_cnt_d = rearm_cnt_q;
        sub_cnt_d   = sub_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        baud_div_d  = baud_div_q;
        rx_sel_d    = rx_sel_q;
        ab_accept   = 1'b0;
        wr_evt      = 1'b0;

        if (host_ok) begin
            baud_div_d  = host_div;
            wr_evt      = 1'b1;
            rearm_cnt_d = '0;
            sub_cnt_d   = '0;
            bit_cnt_d   = '0;
            state_d     = host_lock ? ST_FORCED : ST_LOCKED;
        end else if (!(host_lock && (state_q != ST_FORCED))) begin
            // host_lock outside FORCED freezes everything until a host write arrives.
            case (state_q)
                ST_REARM: begin
                    if (rearm_cnt_q == REARM_LAST) begin
                        rearm_cnt_d = '0;
                        state_d     = ST_HUNT;
                    end else begin
                        rearm_cnt_d = rearm_cnt_q + RCW'(1);
                    end
                end
                ST_HUNT: begin
                    if (ab_wr) begin
                        if (ab_div >= MIN_DIV) begin
                            baud_div_d = ab_div;
                            wr_evt     = 1'b1;
                            ab_accept  = 1'b1;
                            state_d    = ST_LOCKED;
                        end else begin
                            state_d = ST_REARM;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (rx) begin
                        sub_cnt_d = '0;
                        bit_cnt_d = '0;
                    end else if (sub_cnt_q == bit_last) begin
                        sub_cnt_d = '0;
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = ST_REARM;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else begin
                        sub_cnt_d = sub_cnt_q + 13'd1;
                    end
                end
                ST_FORCED: begin
                    sub_cnt_d = '0;
                    bit_cnt_d = '0;
                    if (!host_lock) begin
                        state_d = ST_REARM;
                    end
                end
                default: state_d = ST_REARM;
            endcase
        end

        if ((ab_rx_sel != 2'd0) && !host_lock && ((state_q == ST_LOCKED) || ab_accept)) begin
            rx_sel_d = ab_rx_sel;
        end

        // A write landing while the strobe is high is deferred one cycle so pulses never abut.
        baud_wr_d  = (wr_evt || wr_pend_q) && !baud_wr_q;
        wr_pend_d  = (wr_evt || wr_pend_q) && baud_wr_q;
        ab_rst_n_d = (state_d != ST_REARM);
        ab_dis_d   = (state_d == ST_FORCED) || host_lock;
        locked_d   = (state_d == ST_LOCKED) || (state_d == ST_FORCED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_REARM;
            rearm_cnt_q <= '0;
            sub_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            ab_rst_n_q  <= 1'b0;
            ab_dis_q    <= 1'b0;
            baud_div_q  <= DEFAULT_DIV;
            baud_wr_q   <= 1'b0;
            wr_pend_q   <= 1'b0;
            rx_sel_q    <= 2'd0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rearm_cnt_q <= rearm_cnt_d;
            sub_cnt_q   <= sub_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            ab_rst_n_q  <= ab_rst_n_d;
            ab_dis_q    <= ab_dis_d;
            baud_div_q  <= baud_div_d;
            baud_wr_q   <= baud_wr_d;
            wr_pend_q   <= wr_pend_d;
            rx_sel_q    <= rx_sel_d;
            locked_q    <= locked_d;
        end
    end

    assign state       = state_q;
    assign ab_rst_n    = ab_rst_n_q;
    assign ab_disabled = ab_dis_q;
    assign baud_div    = baud_div_q;
    assign baud_wr     = baud_wr_q;
    assign rx_sel      = rx_sel_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_debug_baud_ctrl.sv
// Randomised bench for debug_baud_ctrl against a behavioural model, plus directed literal checks.
module tb_debug_baud_ctrl;

    localparam int REARM_CYC  = 4;
    localparam int BREAK_BITS = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic       ab_wr;
    logic [7:0] ab_div;
    logic [1:0] ab_rx_sel;
    logic       ab_rst_n;
    logic       ab_disabled;
    logic       host_wr;
    logic [7:0] host_div;
    logic       host_lock;
    logic       rx;
    logic       baud_wr;
    logic [7:0] baud_div;
    logic [1:0] rx_sel;
    logic       locked;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: state number, cycles spent re-arming, length of the current low run on rx.
    int m_state, m_rearm, m_low, m_div, m_rxsel, m_owed, m_wr, m_dis;
    int prev_wr = 0;

    debug_baud_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .ab_wr      (ab_wr),
        .ab_div     (ab_div),
        .ab_rx_sel  (ab_rx_sel),
        .ab_rst_n   (ab_rst_n),
        .ab_disabled(ab_disabled),
        .host_wr    (host_wr),
        .host_div   (host_div),
        .host_lock  (host_lock),
        .rx         (rx),
        .baud_wr    (baud_wr),
        .baud_div   (baud_div),
        .rx_sel     (rx_sel),
        .locked     (locked),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  prev;
        bit  host_ok;
        bit  accept;
        bit  wr;
        if (rst) begin
            m_state = 0; m_rearm = 0; m_low = 0; m_div = 26;
            m_rxsel = 0; m_owed = 0; m_wr = 0; m_dis = 0;
            return;
        end
        prev    = m_state;
        host_ok = host_wr && (host_div != 8'd0);
        accept  = 1'b0;
        wr      = 1'b0;
        if (host_ok) begin
            m_div   = int'(host_div);
            wr      = 1'b1;
            m_state = host_lock ? 3 : 2;
            m_low   = 0;
            m_rearm = 0;
        end else if (!(host_lock && m_state != 3)) begin
            case (m_state)
                0: begin
                    m_rearm++;
                    if (m_rearm == REARM_CYC) begin
                        m_rearm = 0;
                        m_state = 1;
                    end
                end
                1: begin
                    if (ab_wr) begin
                        if (int'(ab_div) >= 2) begin
                            m_div   = int'(ab_div);
                            wr      = 1'b1;
                            accept  = 1'b1;
                            m_state = 2;
                        end else begin
                            m_state = 0;
                        end
                    end
                end
                2: begin
                    if (rx) m_low = 0;
                    else    m_low++;
                    if (m_low == 32 * m_div * BREAK_BITS) begin
                        m_low   = 0;
                        m_state = 0;
                    end
                end
                default: begin
                    m_low = 0;
                    if (!host_lock) m_state = 0;
                end
            endcase
        end
        if (ab_rx_sel != 2'd0 && !host_lock && (prev == 2 || accept)) m_rxsel = int'(ab_rx_sel);
        m_owed = m_owed | int'(wr);
        if (m_owed != 0 && m_wr == 0) begin
            m_wr   = 1;
            m_owed = 0;
        end else begin
            m_wr = 0;
        end
        m_dis = (m_state == 3 || host_lock) ? 1 : 0;
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        chk("state",       int'(state),       m_state);
        chk("ab_rst_n",    int'(ab_rst_n),    (m_state != 0) ? 1 : 0);
        chk("ab_disabled", int'(ab_disabled), m_dis);
        chk("baud_div",    int'(baud_div),    m_div);
        chk("baud_wr",     int'(baud_wr),     m_wr);
        chk("rx_sel",      int'(rx_sel),      m_rxsel);
        chk("locked",      int'(locked),      (m_state >= 2) ? 1 : 0);
        chk("wr_gap",      int'(baud_wr) & prev_wr, 0);
        prev_wr = int'(baud_wr);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int burst;
        rst = 1'b1; ab_wr = 1'b0; ab_div = 8'd0; ab_rx_sel = 2'd0;
        host_wr = 1'b0; host_div = 8'd0; host_lock = 1'b0; rx = 1'b1;
        cyc(3);
        chk("rst_state", int'(state), 0);
        chk("rst_div",   int'(baud_div), 26);
        chk("rst_abrst", int'(ab_rst_n), 0);
        chk("rst_lock",  int'(locked), 0);
        rst = 1'b0;
        cyc(3);
        chk("rearm_low3", int'(ab_rst_n), 0);
        cyc(1);
        chk("rearm_high", int'(ab_rst_n), 1);
        chk("hunt_state", int'(state), 1);
        chk("hunt_div",   int'(baud_div), 26);

        // Rejected divisor re-arms without touching baud_div.
        ab_wr = 1'b1; ab_div = 8'd1;
        cyc(1);
        ab_wr = 1'b0;
        chk("bad_state", int'(state), 0);
        chk("bad_div",   int'(baud_div), 26);
        chk("bad_wr",    int'(baud_wr), 0);
        cyc(4);
        chk("bad_hunt", int'(state), 1);

        ab_wr = 1'b1; ab_div = 8'd13; ab_rx_sel = 2'd2;
        cyc(1);
        ab_wr = 1'b0;
        chk("acc_wr",    int'(baud_wr), 1);
        chk("acc_div",   int'(baud_div), 13);
        chk("acc_state", int'(state), 2);
        chk("acc_rxsel", int'(rx_sel), 2);
        cyc(1);
        chk("acc_wr_end", int'(baud_wr), 0);

        // Break detection at div=4: 12 bit-times of 128 clocks.
        host_wr = 1'b1; host_div = 8'd4;
        cyc(1);
        host_wr = 1'b0;
        chk("h4_div", int'(baud_div), 4);
        rx = 1'b0;
        cyc(12 * 128 - 1);
        chk("brk_pre", int'(state), 2);
        cyc(1);
        chk("brk_state", int'(state), 0);
        chk("brk_lock",  int'(locked), 0);
        chk("brk_div",   int'(baud_div), 4);
        rx = 1'b1;
        cyc(4);
        ab_wr = 1'b1; ab_div = 8'd4;
        cyc(1);
        ab_wr = 1'b0;
        rx = 1'b0; cyc(1000);
        rx = 1'b1; cyc(1);
        rx = 1'b0; cyc(12 * 128 - 1);
        chk("nobrk_state", int'(state), 2);
        rx = 1'b1;

        // Host beats the detector in the same cycle.
        host_lock = 1'b1; host_wr = 1'b1; host_div = 8'd50; ab_wr = 1'b1; ab_div = 8'd13;
        cyc(1);
        host_wr = 1'b0; ab_wr = 1'b0;
        chk("frc_wr",    int'(baud_wr), 1);
        chk("frc_div",   int'(baud_div), 50);
        chk("frc_state", int'(state), 3);
        chk("frc_dis",   int'(ab_disabled), 1);
        cyc(1);
        chk("frc_wr1", int'(baud_wr), 0);
        host_lock = 1'b0;
        cyc(1);
        chk("unlock_state", int'(state), 0);
        cyc(4);
        host_wr = 1'b1; host_div = 8'd0;
        cyc(1);
        host_wr = 1'b0;
        chk("z_state", int'(state), 1);
        chk("z_div",   int'(baud_div), 50);
        chk("z_wr",    int'(baud_wr), 0);
        host_wr = 1'b1; host_div = 8'd7;
        cyc(1);
        host_wr = 1'b0;
        chk("pre_rst_wr", int'(baud_wr), 1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("mid_rst_wr",  int'(baud_wr), 0);
        chk("mid_rst_div", int'(baud_div), 26);
        chk("mid_rst_st",  int'(state), 0);

        burst = 0;
        for (int i = 0; i < 20000; i++) begin
            ab_wr     = ($urandom_range(0, 39) == 0);
            ab_div    = 8'($urandom_range(0, 5));
            ab_rx_sel = 2'($urandom_range(0, 3));
            if (burst == 0 && $urandom_range(0, 799) == 0) burst = 3;
            host_wr   = ($urandom_range(0, 299) == 0) || (burst > 0);
            if (burst > 0) burst--;
            host_div  = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 399) == 0) host_lock = !host_lock;
            if (rx) begin
                if ($urandom_range(0, 49) == 0) rx = 1'b0;
            end else if ($urandom_range(0, 1499) == 0) begin
                rx = 1'b1;
            end
            rst = ($urandom_range(0, 2999) == 0);
            cyc(1);
        end
        rst = 1'b0;
        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debug_baud_ctrl.md
Name: debug_baud_ctrl

Overview:
Sequencing controller for the debug auto-baud detector and the debug UART baud generator.
- Arms and re-arms the detector through its active-low reset.
- Validates each divisor the detector reports, then programs the baud generator.
- Arbitrates between auto-detected and host-forced divisors.
- Re-arms detection when a line break (rx held low for several bit times) is seen.

Parameters:
DEFAULT_DIV, 8'd26, baud_div value loaded at reset.
MIN_DIV, 8'd2, smallest detector divisor accepted; ab_div below this is rejected.
REARM_CYC, 4, number of cycles ab_rst_n is held low on each re-arm.
BREAK_BITS, 12, number of consecutive low bit-times on rx that counts as a break.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ab_wr  in  1  detector divisor-valid pulse
ab_div  in  8  detector divisor
ab_rx_sel  in  2  detector-selected RX input (0 = none yet)
ab_rst_n  out  1  active-low reset to the detector
ab_disabled  out  1  disable input to the detector
host_wr  in  1  host divisor write strobe
host_div  in  8  host divisor
host_lock  in  1  keeps the host divisor and suppresses auto-baud while high
rx  in  1  selected RX line, already synchronised
baud_wr  out  1  one-cycle load strobe to the baud generator
baud_div  out  8  divisor presented to the baud generator
rx_sel  out  2  RX input selection for the UART
locked  out  1  a valid divisor is programmed
state  out  2  0=REARM 1=HUNT 2=LOCKED 3=FORCED

Behaviour:
- Reset values: state=REARM, rearm counter=0, ab_rst_n=0, ab_disabled=0, baud_div=DEFAULT_DIV, baud_wr=0, rx_sel=0, locked=0, break counters=0.
- All outputs are registered.
- REARM:
  - ab_rst_n=0 and locked=0.
  - Counter increments each cycle; on reaching REARM_CYC-1, counter clears and state goes to HUNT.
  - ab_rst_n is therefore low for exactly REARM_CYC cycles.
- HUNT:
  - ab_rst_n=1.
  - ab_wr with ab_div>=MIN_DIV: on the next edge baud_div<=ab_div, baud_wr=1 for one cycle, locked<=1, state<=LOCKED.
  - ab_wr with ab_div<MIN_DIV: state<=REARM; baud_div is unchanged.
- LOCKED:
  - Whenever ab_rx_sel!=0, rx_sel<=ab_rx_sel; a value of 0 never overwrites rx_sel.
  - Break detector runs. Bit-time = {baud_div,5'b0} clks, because the detector reports pulse_width/32.
  - 13-bit sub counter counts clks while rx==0 and wraps at bit-time-1, incrementing a 4-bit bit counter.
  - Any rx==1 clears both counters.
  - When the bit counter reaches BREAK_BITS: state<=REARM, locked<=0, counters clear. baud_div and rx_sel are retained.
- FORCED:
  - ab_disabled=1 and ab_rst_n=1.
  - Break detector is inactive and its counters are held at 0.
  - host_lock falling while in FORCED: state<=REARM; baud_div and rx_sel are retained.
- Host write (any state):
  - host_wr with host_div!=0: next edge baud_div<=host_div, baud_wr pulses, locked<=1.
  - Then, if host_lock=1, state<=FORCED. Otherwise state<=LOCKED and the break counters clear.
  - host_wr with host_div==0 is ignored entirely.
- host_lock=1 while not in FORCED, with no host_wr: ab_disabled=1 and the state is held. No transition is made until host_wr.
- Simultaneous ab_wr and valid host_wr: host wins and the ab_wr is dropped. Exactly one baud_wr pulse is produced.
- baud_wr is never high on two consecutive cycles. A write arriving while baud_wr=1 is registered and pulses again one cycle later.
- rst asserted mid-operation: all state returns to reset values on that edge, regardless of any pending write.

Test Plan:
1. Release rst → ab_rst_n low for 4 cycles then high; state=1; baud_div=26, locked=0, baud_wr=0.
2. HUNT, ab_wr with ab_div=8'd13 and ab_rx_sel=2 → one-cycle baud_wr, baud_div=13, locked=1, state=2, rx_sel=2.
3. HUNT, ab_wr with ab_div=1 → state=0, ab_rst_n low 4 cycles, baud_div stays 26, no baud_wr.
4. LOCKED with div=4 (bit-time 128), rx low 12*128-1 clks → still LOCKED; one more clk → state=0, locked=0. Repeat with rx high for 1 clk at 1000 → counters restart, no break.
5. host_lock=1 and host_wr host_div=50 in the same cycle as ab_wr div=13 → single baud_wr, baud_div=50, state=3, ab_disabled=1. Drop host_lock → state=0.
6. host_wr with host_div=0 → no change to any output. rst asserted during a baud_wr pulse → baud_wr=0 and all outputs at reset values next cycle.
